// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory bundle for the boot loader.
// The loader binds to the slave modport; the source to the master.
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [7:0]        word_count;
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              error;

   modport master (
      output start, word_count, in_valid, in_byte,
      input  in_ready, imem_we, imem_addr, imem_wdata,
      input  cpu_reset, busy, done, error
   );

   modport slave (
      input  start, word_count, in_valid, in_byte,
      output in_ready, imem_we, imem_addr, imem_wdata,
      output cpu_reset, busy, done, error
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: bytes -> LE words -> imem, trailing checksum,
// holds the core in reset until a load completes cleanly.
module imem_loader #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_RECV, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        byte_idx;
   logic [7:0]        word_cnt;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;

   logic in_ready_c, imem_we_c, busy_c, done_c, error_c, cpu_reset_c;
   logic xfer, can_start, start_ok;

   assign xfer      = bus.in_valid && in_ready_c;
   assign can_start = (state == S_IDLE) || (state == S_DONE) ||
                      (state == S_ERR);
   assign start_ok  = can_start && bus.start;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      imem_we_c   = 1'b0;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      error_c     = 1'b0;
      cpu_reset_c = 1'b1;
      unique case (state)
         S_IDLE, S_DONE, S_ERR: begin
            done_c      = (state == S_DONE);
            error_c     = (state == S_ERR);
            cpu_reset_c = (state != S_DONE);
            if (bus.start)
               state_nxt = (bus.word_count == 8'd0) ? S_CSUM : S_RECV;
         end
         S_RECV: begin
            in_ready_c = 1'b1;
            busy_c     = 1'b1;
            if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            imem_we_c = 1'b1;
            busy_c    = 1'b1;
            state_nxt = (word_cnt > 8'd1) ? S_RECV : S_CSUM;
         end
         S_CSUM: begin
            in_ready_c = 1'b1;
            busy_c     = 1'b1;
            if (xfer)
               state_nxt = (bus.in_byte == csum) ? S_DONE : S_ERR;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Word assembly, checksum, address and word counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_idx <= 2'd0;
         word_cnt <= 8'd0;
         csum     <= 8'd0;
         addr     <= BASE_ADDR;
         wdata    <= 32'd0;
      end else if (start_ok) begin
         byte_idx <= 2'd0;
         word_cnt <= bus.word_count;
         csum     <= 8'd0;
         addr     <= BASE_ADDR;
      end else if (state == S_RECV && xfer) begin
         wdata[byte_idx*8 +: 8] <= bus.in_byte;
         csum                   <= csum + bus.in_byte;
         byte_idx               <= byte_idx + 2'd1;
      end else if (state == S_WRITE) begin
         addr     <= addr + ADDR_W'(4);
         word_cnt <= word_cnt - 8'd1;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.imem_we    = imem_we_c;
   assign bus.imem_addr  = addr;
   assign bus.imem_wdata = wdata;
   assign bus.cpu_reset  = cpu_reset_c;
   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.error      = error_c;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances share one stream,
// one at base 0x00 and one at base 0xF8 for the wrap case.
module tb_imem_loader;
   logic clk;
   logic reset;
   int   cyc;
   int   n_chk;
   int   n_fail;
   int   ready_bad;
   int   t_start;
   int   t_end;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   logic [31:0] wa2[$];
   logic [7:0]  stream[$];

   imem_loader_if #(.ADDR_W(8)) bus ();
   imem_loader_if #(.ADDR_W(8)) bus2 ();

   assign bus2.start      = bus.start;
   assign bus2.word_count = bus.word_count;
   assign bus2.in_valid   = bus.in_valid;
   assign bus2.in_byte    = bus.in_byte;

   imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hF8)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.imem_we) begin
         wa.push_back(32'(bus.imem_addr));
         wd.push_back(bus.imem_wdata);
         if (bus.in_ready) ready_bad++;
      end
      if (bus2.imem_we) wa2.push_back(32'(bus2.imem_addr));
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] wc);
      @(negedge clk);
      wa.delete();
      wd.delete();
      wa2.delete();
      bus.word_count = wc;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      t_start   = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int g;
      g = 0;
      bus.in_byte  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) chk("ready_timeout", 32'(g), 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_stream(input bit rnd, input int mid);
      for (int i = 0; i < stream.size(); i++) begin
         if (rnd) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         if (i == mid) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
         end
         send_byte(stream[i]);
      end
   endtask

   task automatic wait_end();
      int g;
      g = 0;
      while (!(bus.done || bus.error) && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) chk("end_timeout", 32'(g), 32'd0);
      t_end = cyc;
   endtask

   task automatic load_two(input logic [7:0] cs);
      stream = '{8'h13, 8'h05, 8'h00, 8'h00,
                 8'h93, 8'h05, 8'h15, 8'h00, cs};
   endtask

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      ready_bad    = 0;
      cyc          = 0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.word_count = 8'd0;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
      chk("rst_addr", 32'(bus.imem_addr), 32'h00);
      chk("rst_addr2", 32'(bus2.imem_addr), 32'hF8);
      chk("rst_wdata", bus.imem_wdata, 32'd0);
      chk("rst_flags", {29'd0, bus.busy, bus.done, bus.error}, 32'd0);
      reset = 1'b0;

      // two-word clean load, best-case timing
      load_two(8'hC5);
      do_start(8'd2);
      chk("t1_ready_after_start", 32'(bus.in_ready), 32'd1);
      chk("t1_cpu_reset_busy", 32'(bus.cpu_reset), 32'd1);
      send_stream(1'b0, -1);
      wait_end();
      chk("t1_latency", 32'(t_end - t_start), 32'd11);
      chk("t1_nwr", 32'(wa.size()), 32'd2);
      chk("t1_addr0", wa[0], 32'h00);
      chk("t1_data0", wd[0], 32'h00000513);
      chk("t1_addr1", wa[1], 32'h04);
      chk("t1_data1", wd[1], 32'h00150593);
      chk("t1_done", 32'(bus.done), 32'd1);
      chk("t1_error", 32'(bus.error), 32'd0);
      chk("t1_cpu_reset", 32'(bus.cpu_reset), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd0);

      // zero words, good and bad checksum
      stream = '{8'h00};
      do_start(8'd0);
      chk("t2_rst_rise", 32'(bus.cpu_reset), 32'd1);
      send_stream(1'b0, -1);
      wait_end();
      chk("t2_done", 32'(bus.done), 32'd1);
      chk("t2_nwr", 32'(wa.size()), 32'd0);
      stream = '{8'h01};
      do_start(8'd0);
      send_stream(1'b0, -1);
      wait_end();
      chk("t2b_error", 32'(bus.error), 32'd1);
      chk("t2b_done", 32'(bus.done), 32'd0);
      chk("t2b_cpu_reset", 32'(bus.cpu_reset), 32'd1);

      // wrong checksum still writes both words
      load_two(8'h00);
      do_start(8'd2);
      send_stream(1'b0, -1);
      wait_end();
      chk("t3_nwr", 32'(wa.size()), 32'd2);
      chk("t3_data0", wd[0], 32'h00000513);
      chk("t3_data1", wd[1], 32'h00150593);
      chk("t3_flags", {29'd0, bus.cpu_reset, bus.done, bus.error},
          32'b101);

      // random valid gaps plus a start pulse mid-load
      load_two(8'hC5);
      ready_bad = 0;
      do_start(8'd2);
      send_stream(1'b1, 3);
      wait_end();
      chk("t4_nwr", 32'(wa.size()), 32'd2);
      chk("t4_addr0", wa[0], 32'h00);
      chk("t4_data0", wd[0], 32'h00000513);
      chk("t4_addr1", wa[1], 32'h04);
      chk("t4_data1", wd[1], 32'h00150593);
      chk("t4_done", 32'(bus.done), 32'd1);
      chk("t4_ready_in_write", 32'(ready_bad), 32'd0);

      // async reset after 6 bytes
      stream = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05};
      do_start(8'd2);
      send_stream(1'b0, -1);
      #2 reset = 1'b1;
      #1;
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t5_addr", 32'(bus.imem_addr), 32'h00);
      chk("t5_wdata", bus.imem_wdata, 32'd0);
      @(negedge clk);
      chk("t5_nwr", 32'(wa.size()), 32'd1);
      chk("t5_we", 32'(bus.imem_we), 32'd0);
      reset = 1'b0;
      load_two(8'hC5);
      do_start(8'd2);
      send_stream(1'b0, -1);
      wait_end();
      chk("t5_reload_done", 32'(bus.done), 32'd1);
      chk("t5_reload_data1", wd[1], 32'h00150593);

      // three words on the 0xF8 instance: address wrap
      stream = '{8'h01, 8'h00, 8'h00, 8'h00,
                 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h03, 8'h00, 8'h00, 8'h00, 8'h06};
      do_start(8'd3);
      send_stream(1'b0, -1);
      wait_end();
      chk("t6_nwr", 32'(wa2.size()), 32'd3);
      chk("t6_addr0", wa2[0], 32'hF8);
      chk("t6_addr1", wa2[1], 32'hFC);
      chk("t6_addr2", wa2[2], 32'h00);
      chk("t6_done", 32'(bus2.done), 32'd1);
      chk("t6_data2", wd[2], 32'h00000003);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
